// File: rtl/aukv_pkg.sv
// Purpose : shared Auk-V definitions for the writeback stage (load funct3 codes, FSM states, XLEN).
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package aukv_pkg;

   localparam int XLEN_DEFAULT = 32;

   // RV32I load size/sign encodings carried in funct3
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_WAIT_LOAD = 1'b1
   } wb_state_e;

endpackage

// File: rtl/aukv_wb_stage_if.sv
// Purpose : bundles the writeback stage's MEM-side handshake, dmem response, RF write and forwarding signals.
// Latency : n/a (wiring only).
// Backpr. : o_ready is driven by the stage; master = MEM/dmem/RF side, slave = writeback stage.
interface aukv_wb_stage_if
   import aukv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
);
   logic            i_valid;
   logic            o_ready;
   logic [4:0]      i_rd_addr;
   logic            i_rd_we;
   logic            i_is_load;
   logic [2:0]      i_funct3;
   logic [1:0]      i_addr_lo;
   logic [XLEN-1:0] i_alu_result;
   logic            i_dmem_rvalid;
   logic [XLEN-1:0] i_dmem_rdata;
   logic            o_rf_we;
   logic [4:0]      o_rf_addr;
   logic [XLEN-1:0] o_rf_data;
   logic            o_fwd_valid;
   logic [4:0]      o_fwd_addr;
   logic            o_load_fault;

   modport master (
      output i_valid, i_rd_addr, i_rd_we, i_is_load, i_funct3, i_addr_lo, i_alu_result,
             i_dmem_rvalid, i_dmem_rdata,
      input  o_ready, o_rf_we, o_rf_addr, o_rf_data, o_fwd_valid, o_fwd_addr, o_load_fault
   );

   modport slave (
      input  i_valid, i_rd_addr, i_rd_we, i_is_load, i_funct3, i_addr_lo, i_alu_result,
             i_dmem_rvalid, i_dmem_rdata,
      output o_ready, o_rf_we, o_rf_addr, o_rf_data, o_fwd_valid, o_fwd_addr, o_load_fault
   );
endinterface

// File: rtl/aukv_load_align.sv
// Purpose : selects the addressed byte/halfword of a word-aligned load and sign/zero-extends it.
// Latency : combinational.
// Backpr. : none.
// Ports   : rdata_i raw word, funct3_i load type, addr_lo_i byte offset, data_o extended result.
module aukv_load_align
   import aukv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
      // addr_lo[0] is ignored for halfwords; misaligned accesses trap upstream
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      data_o   = rdata_i;
      case (funct3_i)
         F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
         F3_LW:   data_o = rdata_i;
         default: data_o = rdata_i;  // undefined codes read the full word
      endcase
   end

endmodule

// File: rtl/aukv_wb_stage.sv
// Purpose : Auk-V writeback stage, sole writer of the integer register file; aligns load data.
// Latency : non-load retires one cycle after handshake; load retires one cycle after i_dmem_rvalid.
// Backpr. : o_ready=1 in IDLE only; a load holds o_ready low until its response (or timeout).
// Ports   : i_clk/i_rst (sync, active-high), wb = slave side of aukv_wb_stage_if.
// Option  : AUKV_WB_LOAD_TIMEOUT_EN adds a LOAD_TIMEOUT-cycle watchdog driving o_load_fault.
module aukv_wb_stage
   import aukv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
`ifdef AUKV_WB_LOAD_TIMEOUT_EN
   , parameter int LOAD_TIMEOUT = 16
`endif
) (
   input  logic               i_clk,
   input  logic               i_rst,
   aukv_wb_stage_if.slave     wb
);

   wb_state_e       state_q, state_d;
   logic [4:0]      rd_addr_q, rd_addr_d;
   logic            rd_we_q, rd_we_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [1:0]      addr_lo_q, addr_lo_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_addr_q, rf_addr_d;
   logic [XLEN-1:0] rf_data_q, rf_data_d;
   logic [XLEN-1:0] load_data;
   logic            expire;

   aukv_load_align #(.XLEN(XLEN)) u_align (
      .rdata_i   (wb.i_dmem_rdata),
      .funct3_i  (funct3_q),
      .addr_lo_i (addr_lo_q),
      .data_o    (load_data)
   );

`ifdef AUKV_WB_LOAD_TIMEOUT_EN
   localparam int CW = $clog2(LOAD_TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fault_q;

   // cnt_q counts completed wait cycles; the final wait cycle is the one seeing LOAD_TIMEOUT-1.
   // A response in that same cycle still wins.
   assign expire = (state_q == ST_WAIT_LOAD) && !wb.i_dmem_rvalid &&
                   (cnt_q == CW'(LOAD_TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE)
         cnt_d = '0;
      else
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         fault_q <= expire;
      end
   end

   assign wb.o_load_fault = fault_q;
`else
   assign expire          = 1'b0;
   assign wb.o_load_fault = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      rd_we_d   = rd_we_q;
      funct3_d  = funct3_q;
      addr_lo_d = addr_lo_q;
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      case (state_q)
         ST_IDLE: begin
            if (wb.i_valid) begin
               if (wb.i_is_load) begin
                  rd_addr_d = wb.i_rd_addr;
                  rd_we_d   = wb.i_rd_we;
                  funct3_d  = wb.i_funct3;
                  addr_lo_d = wb.i_addr_lo;
                  state_d   = ST_WAIT_LOAD;
               end else begin
                  // x0 is never written so it reads zero regardless of the RF
                  rf_we_d   = wb.i_rd_we && (wb.i_rd_addr != 5'd0);
                  rf_addr_d = wb.i_rd_addr;
                  rf_data_d = wb.i_alu_result;
               end
            end
         end
         ST_WAIT_LOAD: begin
            if (wb.i_dmem_rvalid) begin
               rf_we_d   = rd_we_q && (rd_addr_q != 5'd0);
               rf_addr_d = rd_addr_q;
               rf_data_d = load_data;
               state_d   = ST_IDLE;
            end else if (expire) begin
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         rd_addr_q <= 5'd0;
         rd_we_q   <= 1'b0;
         funct3_q  <= 3'd0;
         addr_lo_q <= 2'd0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= 5'd0;
         rf_data_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         rd_we_q   <= rd_we_d;
         funct3_q  <= funct3_d;
         addr_lo_q <= addr_lo_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   // o_ready depends on state only, so there is no combinational path from i_valid
   assign wb.o_ready     = (state_q == ST_IDLE);
   assign wb.o_fwd_valid = (state_q == ST_WAIT_LOAD) && rd_we_q && (rd_addr_q != 5'd0);
   assign wb.o_fwd_addr  = (state_q == ST_WAIT_LOAD) ? rd_addr_q : 5'd0;
   assign wb.o_rf_we     = rf_we_q;
   assign wb.o_rf_addr   = rf_addr_q;
   assign wb.o_rf_data   = rf_data_q;

endmodule
